// File: rtl/nn_pkg.sv
// Shared types and constants for the layer MAC sequencer.
// Holds the sequencer state encoding and the per-neuron period helper.
package nn_pkg;

    localparam int DATA_W = 16;
    localparam int ACC_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } seq_state_t;

    // Cycles spent on one neuron: clear, stream, drain, write.
    function automatic int neuron_period(input int in_size, input int mem_lat);
        return in_size + mem_lat + 2;
    endfunction

endpackage

// File: rtl/valid_delay_line.sv
// Delays the issue-valid and last flags by the memory read latency
// so MAC enables line up with returning read data.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic valid_in,
    input  logic last_in,
    output logic valid_out,
    output logic last_out
);

    logic [DEPTH-1:0] v_sr;
    logic [DEPTH-1:0] l_sr;

    // Shift register per flag; flush empties the whole pipe at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_sr <= '0;
            l_sr <= '0;
        end else if (flush) begin
            v_sr <= '0;
            l_sr <= '0;
        end else begin
            v_sr[0] <= valid_in;
            l_sr[0] <= last_in;
            for (int k = 1; k < DEPTH; k++) begin
                v_sr[k] <= v_sr[k-1];
                l_sr[k] <= l_sr[k-1];
            end
        end
    end

    assign valid_out = v_sr[DEPTH-1];
    assign last_out  = l_sr[DEPTH-1];

endmodule

// File: rtl/layer_mac_sequencer.sv
// Sequences one serial MAC datapath over every neuron of a layer:
// address generation, latency-aligned MAC enables and result commit.
module layer_mac_sequencer
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE   = 784,
    parameter int NUM_NEURONS  = 64,
    parameter int ADDR_WIDTH   = 10,
    parameter int NEURON_WIDTH = 6,
    parameter int W_ADDR_WIDTH = 16,
    parameter int MEM_LATENCY  = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   in_addr,
    output logic [W_ADDR_WIDTH-1:0] w_addr,
    output logic [NEURON_WIDTH-1:0] b_addr,
    output logic                    mac_clr,
    output logic                    mac_en,
    output logic                    acc_last,
    output logic                    out_we,
    output logic [NEURON_WIDTH-1:0] out_addr
);

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0]   LAST_I = ADDR_WIDTH'(INPUT_SIZE - 1);
    localparam logic [NEURON_WIDTH-1:0] LAST_N = NEURON_WIDTH'(NUM_NEURONS - 1);
    localparam logic [CW-1:0]           LAST_D = CW'(MEM_LATENCY - 1);
    localparam logic [W_ADDR_WIDTH-1:0] W_STEP = W_ADDR_WIDTH'(INPUT_SIZE);

    seq_state_t state;
    seq_state_t state_nxt;

    logic [ADDR_WIDTH-1:0]   i;
    logic [NEURON_WIDTH-1:0] neuron;
    logic [W_ADDR_WIDTH-1:0] w_base;
    logic [CW-1:0]           d_cnt;
    logic                    issue;
    logic                    issue_last;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:   if (start && !abort) state_nxt = S_CLEAR;
            S_CLEAR:  state_nxt = S_STREAM;
            S_STREAM: if (i == LAST_I) state_nxt = S_DRAIN;
            S_DRAIN:  if (d_cnt == LAST_D) state_nxt = S_WRITE;
            S_WRITE:  state_nxt = (neuron == LAST_N) ? S_DONE : S_CLEAR;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort && state != S_IDLE) state_nxt = S_IDLE;
    end

    // Element, drain, neuron and weight-base counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i      <= '0;
            neuron <= '0;
            w_base <= '0;
            d_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    neuron <= '0;
                    w_base <= '0;
                end
                S_CLEAR: begin
                    i     <= '0;
                    d_cnt <= '0;
                end
                S_STREAM: if (i != LAST_I) i <= i + 1'b1;
                S_DRAIN:  if (d_cnt != LAST_D) d_cnt <= d_cnt + 1'b1;
                S_WRITE: begin
                    if (neuron != LAST_N) begin
                        neuron <= neuron + 1'b1;
                        w_base <= w_base + W_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        issue      = (state == S_STREAM);
        issue_last = issue && (i == LAST_I);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
        mac_clr    = (state == S_CLEAR);
        out_we     = (state == S_WRITE);
        in_addr    = issue ? i : '0;
        w_addr     = issue ? (w_base + W_ADDR_WIDTH'(i)) : '0;
        b_addr     = (busy && !done) ? neuron : '0;
        out_addr   = out_we ? neuron : '0;
    end

    valid_delay_line #(
        .DEPTH(MEM_LATENCY)
    ) u_vdl (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (abort),
        .valid_in (issue),
        .last_in  (issue_last),
        .valid_out(mac_en),
        .last_out (acc_last)
    );

endmodule

// File: tb/tb_layer_mac_sequencer.sv
// Self-checking bench for layer_mac_sequencer across three configurations.
// A cycle-indexed model predicts every output; literals pin key events.
module tb_layer_mac_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start[3];
    logic        abort[3];
    logic        busy[3];
    logic        done[3];
    logic        mac_clr[3];
    logic        mac_en[3];
    logic        acc_last[3];
    logic        out_we[3];
    logic [9:0]  in_addr[3];
    logic [15:0] w_addr[3];
    logic [5:0]  b_addr[3];
    logic [5:0]  out_addr[3];

    layer_mac_sequencer #(.INPUT_SIZE(4), .NUM_NEURONS(3), .MEM_LATENCY(1)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
        .busy(busy[0]), .done(done[0]), .in_addr(in_addr[0]), .w_addr(w_addr[0]),
        .b_addr(b_addr[0]), .mac_clr(mac_clr[0]), .mac_en(mac_en[0]),
        .acc_last(acc_last[0]), .out_we(out_we[0]), .out_addr(out_addr[0]));

    layer_mac_sequencer #(.INPUT_SIZE(4), .NUM_NEURONS(3), .MEM_LATENCY(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
        .busy(busy[1]), .done(done[1]), .in_addr(in_addr[1]), .w_addr(w_addr[1]),
        .b_addr(b_addr[1]), .mac_clr(mac_clr[1]), .mac_en(mac_en[1]),
        .acc_last(acc_last[1]), .out_we(out_we[1]), .out_addr(out_addr[1]));

    layer_mac_sequencer #(.INPUT_SIZE(2), .NUM_NEURONS(1), .MEM_LATENCY(1)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .abort(abort[2]),
        .busy(busy[2]), .done(done[2]), .in_addr(in_addr[2]), .w_addr(w_addr[2]),
        .b_addr(b_addr[2]), .mac_clr(mac_clr[2]), .mac_en(mac_en[2]),
        .acc_last(acc_last[2]), .out_we(out_we[2]), .out_addr(out_addr[2]));

    function automatic int cfg_is(input int d);
        return (d == 2) ? 2 : 4;
    endfunction
    function automatic int cfg_nn(input int d);
        return (d == 2) ? 1 : 3;
    endfunction
    function automatic int cfg_lat(input int d);
        return (d == 1) ? 3 : 1;
    endfunction

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, a, e, cyc);
        end
    endtask

    // Model: t = position within the pass, 1 = CLEAR of neuron 0.
    bit act[3] = '{0, 0, 0};
    int t[3]   = '{0, 0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 3; d++) begin
                act[d] <= 1'b0;
                t[d]   <= 0;
            end
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (act[d]) begin
                    if (abort[d] ||
                        t[d] == cfg_nn(d) * (cfg_is(d) + cfg_lat(d) + 2) + 1)
                        act[d] <= 1'b0;
                    else
                        t[d] <= t[d] + 1;
                end else if (start[d] && !abort[d]) begin
                    act[d] <= 1'b1;
                    t[d]   <= 1;
                end
            end
        end
    end

    // Event log for the DUT under directed study, indexed by cycle since start.
    int sel = 0;
    int s0  = 1000000;
    bit clr_at[128];
    bit we_at[128];
    bit done_at[128];
    bit en_at[128];
    bit last_at[128];
    int wlog[128];
    int olog[128];

    function automatic int cnt(input bit a[128], input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) c += a[k];
        return c;
    endfunction

    // Compare every DUT against the model each cycle, then log.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            automatic int is = cfg_is(d);
            automatic int l  = cfg_lat(d);
            automatic int p  = is + l + 2;
            automatic int dt = cfg_nn(d) * p + 1;
            automatic bit ip = act[d] && t[d] < dt;
            automatic int n  = act[d] ? (t[d] - 1) / p : 0;
            automatic int k  = act[d] ? (t[d] - 1) % p : 0;
            automatic bit st = ip && k >= 1 && k <= is;
            chk($sformatf("u%0d.busy", d), 32'(busy[d]), 32'(act[d]));
            chk($sformatf("u%0d.done", d), 32'(done[d]), 32'(act[d] && t[d] == dt));
            chk($sformatf("u%0d.mac_clr", d), 32'(mac_clr[d]), 32'(ip && k == 0));
            chk($sformatf("u%0d.mac_en", d), 32'(mac_en[d]),
                32'(ip && k >= 1 + l && k <= is + l));
            chk($sformatf("u%0d.acc_last", d), 32'(acc_last[d]), 32'(ip && k == is + l));
            chk($sformatf("u%0d.out_we", d), 32'(out_we[d]), 32'(ip && k == p - 1));
            if (ip && k == p - 1)
                chk($sformatf("u%0d.out_addr", d), 32'(out_addr[d]), 32'(n));
            if (ip)
                chk($sformatf("u%0d.b_addr", d), 32'(b_addr[d]), 32'(n));
            if (st) begin
                chk($sformatf("u%0d.in_addr", d), 32'(in_addr[d]), 32'(k - 1));
                chk($sformatf("u%0d.w_addr", d), 32'(w_addr[d]), 32'(n * is + k - 1));
            end
        end
        if (cyc - s0 + 1 >= 0 && cyc - s0 + 1 < 128) begin
            automatic int r = cyc - s0 + 1;
            clr_at[r]  = mac_clr[sel];
            we_at[r]   = out_we[sel];
            done_at[r] = done[sel];
            en_at[r]   = mac_en[sel];
            last_at[r] = acc_last[sel];
            wlog[r]    = int'(w_addr[sel]);
            olog[r]    = int'(out_addr[sel]);
        end
    end

    task automatic clear_log();
        for (int k = 0; k < 128; k++) begin
            clr_at[k]  = 0;
            we_at[k]   = 0;
            done_at[k] = 0;
            en_at[k]   = 0;
            last_at[k] = 0;
            wlog[k]    = 0;
            olog[k]    = 0;
        end
    endtask

    task automatic pulse_start(input int d);
        sel = d;
        @(posedge clk);
        #2 start[d] = 1'b1;
        @(posedge clk);
        #1 s0 = cyc;
        clear_log();
        #1 start[d] = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        bit hit = 0;
        for (int n = 0; n < 500; n++) begin
            if (cyc - s0 + 1 >= r) begin
                hit = 1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!hit) begin
            n_chk++;
            n_fail++;
            $display("FAIL wait_rel: cycle %0d never reached", r);
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            start[d] = 1'b0;
            abort[d] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy[0]), 0);
        chk("reset.w_addr", 32'(w_addr[1]), 0);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Basic pass, INPUT_SIZE=4 NUM_NEURONS=3 latency 1.
        pulse_start(0);
        repeat (25) @(posedge clk);
        #2;
        chk("p1.clr1", 32'(clr_at[1]), 1);
        chk("p1.clr8", 32'(clr_at[8]), 1);
        chk("p1.clr15", 32'(clr_at[15]), 1);
        chk("p1.clr_cnt", 32'(cnt(clr_at, 0, 26)), 3);
        chk("p1.we7", 32'(we_at[7]), 1);
        chk("p1.we14", 32'(we_at[14]), 1);
        chk("p1.we21", 32'(we_at[21]), 1);
        chk("p1.oa14", 32'(olog[14]), 1);
        chk("p1.oa21", 32'(olog[21]), 2);
        chk("p1.wa2", 32'(wlog[2]), 0);
        chk("p1.wa5", 32'(wlog[5]), 3);
        chk("p1.wa9", 32'(wlog[9]), 4);
        chk("p1.wa19", 32'(wlog[19]), 11);
        chk("p1.done22", 32'(done_at[22]), 1);
        chk("p1.done_cnt", 32'(cnt(done_at, 0, 26)), 1);

        // Start held high, then abort the restarted pass at neuron 1, i=2.
        sel = 0;
        @(posedge clk);
        #2 start[0] = 1'b1;
        @(posedge clk);
        #1 s0 = cyc;
        clear_log();
        #1;
        wait_rel(25);
        start[0] = 1'b0;
        wait_rel(34);
        abort[0] = 1'b1;
        @(posedge clk);
        #2 abort[0] = 1'b0;
        repeat (22) @(posedge clk);
        #2;
        chk("hold.done_cnt", 32'(cnt(done_at, 1, 60)), 1);
        chk("hold.done22", 32'(done_at[22]), 1);
        chk("hold.clr23", 32'(clr_at[23]), 0);
        chk("hold.clr24", 32'(clr_at[24]), 1);
        chk("abort.we30", 32'(we_at[30]), 1);
        chk("abort.en34", 32'(en_at[34]), 1);
        chk("abort.en_after", 32'(cnt(en_at, 35, 60)), 0);
        chk("abort.we_after", 32'(cnt(we_at, 31, 60)), 0);
        chk("abort.clr_after", 32'(cnt(clr_at, 35, 60)), 0);

        pulse_start(0);
        repeat (25) @(posedge clk);
        #2;
        chk("fresh.clr1", 32'(clr_at[1]), 1);
        chk("fresh.we7", 32'(we_at[7]), 1);
        chk("fresh.oa21", 32'(olog[21]), 2);
        chk("fresh.done22", 32'(done_at[22]), 1);

        // Latency 3: P=9.
        pulse_start(1);
        repeat (30) @(posedge clk);
        #2;
        chk("l3.clr10", 32'(clr_at[10]), 1);
        chk("l3.clr19", 32'(clr_at[19]), 1);
        chk("l3.en4", 32'(en_at[4]), 0);
        chk("l3.en5", 32'(en_at[5]), 1);
        chk("l3.en8", 32'(en_at[8]), 1);
        chk("l3.en9", 32'(en_at[9]), 0);
        chk("l3.last8", 32'(last_at[8]), 1);
        chk("l3.last_cnt", 32'(cnt(last_at, 0, 31)), 3);
        chk("l3.en_cnt", 32'(cnt(en_at, 0, 31)), 12);
        chk("l3.we9", 32'(we_at[9]), 1);
        chk("l3.done28", 32'(done_at[28]), 1);
        chk("l3.done_cnt", 32'(cnt(done_at, 0, 31)), 1);

        // Asynchronous reset in the middle of DRAIN.
        pulse_start(1);
        wait_rel(7);
        rst_n = 1'b0;
        #1;
        chk("rst.busy", 32'(busy[1]), 0);
        chk("rst.mac_en", 32'(mac_en[1]), 0);
        chk("rst.b_addr", 32'(b_addr[1]), 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #2;
        chk("rst.done_cnt", 32'(cnt(done_at, 0, 60)), 0);
        chk("rst.we_cnt", 32'(cnt(we_at, 0, 60)), 0);

        // Single neuron, two inputs.
        pulse_start(2);
        repeat (10) @(posedge clk);
        #2;
        chk("one.clr1", 32'(clr_at[1]), 1);
        chk("one.en_cnt", 32'(cnt(en_at, 0, 12)), 2);
        chk("one.last4", 32'(last_at[4]), 1);
        chk("one.we5", 32'(we_at[5]), 1);
        chk("one.oa5", 32'(olog[5]), 0);
        chk("one.done6", 32'(done_at[6]), 1);
        chk("one.done_cnt", 32'(cnt(done_at, 0, 12)), 1);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
